// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} mau_state_t;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    function automatic logic [HALF_W-1:0] sext8to16(input logic [BYTE_W-1:0] b);
        return {{BYTE_W{b[BYTE_W-1]}}, b};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response handshake plus the 8-bit data-memory port.
interface mem_access_unit_if #(
    parameter int AW = 8
);
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic          ReqWide;
    logic          ReqSigned;
    logic [AW-1:0] ReqAddr;
    logic [15:0]   ReqWData;
    logic          RspValid;
    logic [15:0]   RspRData;
    logic [AW-1:0] DataAddress;
    logic          ReadMem;
    logic          WriteMem;
    logic [7:0]    DataIn;
    logic [7:0]    DataOut;

    modport slave (
        input  ReqValid, ReqWrite, ReqWide, ReqSigned, ReqAddr, ReqWData, DataOut,
        output ReqReady, RspValid, RspRData, DataAddress, ReadMem, WriteMem, DataIn
    );

    modport master (
        output ReqValid, ReqWrite, ReqWide, ReqSigned, ReqAddr, ReqWData, DataOut,
        input  ReqReady, RspValid, RspRData, DataAddress, ReadMem, WriteMem, DataIn
    );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences byte/halfword loads and stores as one or two byte accesses on an
// 8-bit memory with combinational reads and clocked writes.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW = 8
) (
    input logic            CLK,
    input logic            Reset_n,
    mem_access_unit_if.slave bus
);

    mau_state_t          state_q, state_d;
    logic                wr_q, wr_d;
    logic                wide_q, wide_d;
    logic                sgn_q, sgn_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [HALF_W-1:0]   wdata_q, wdata_d;
    logic [HALF_W-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]       addr_hi;

    // Halfword high byte wraps around the top of memory.
    assign addr_hi = addr_q + AW'(1);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            wide_q  <= 1'b0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wide_q  <= wide_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // All outputs decode from state and latched registers only.
    always_comb begin
        state_d         = state_q;
        wr_d            = wr_q;
        wide_d          = wide_q;
        sgn_d           = sgn_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        bus.ReqReady    = 1'b0;
        bus.RspValid    = 1'b0;
        bus.RspRData    = '0;
        bus.DataAddress = '0;
        bus.ReadMem     = 1'b0;
        bus.WriteMem    = 1'b0;
        bus.DataIn      = '0;

        case (state_q)
            IDLE: begin
                bus.ReqReady = 1'b1;
                if (bus.ReqValid) begin
                    wr_d    = bus.ReqWrite;
                    wide_d  = bus.ReqWide;
                    sgn_d   = bus.ReqSigned;
                    addr_d  = bus.ReqAddr;
                    wdata_d = bus.ReqWData;
                    rdata_d = '0;
                    state_d = LO;
                end
            end
            LO: begin
                bus.DataAddress = addr_q;
                bus.ReadMem     = ~wr_q;
                bus.WriteMem    = wr_q;
                bus.DataIn      = wr_q ? wdata_q[BYTE_W-1:0] : '0;
                if (!wr_q) rdata_d[BYTE_W-1:0] = bus.DataOut;
                state_d = wide_q ? HI : RESP;
            end
            HI: begin
                bus.DataAddress = addr_hi;
                bus.ReadMem     = ~wr_q;
                bus.WriteMem    = wr_q;
                bus.DataIn      = wr_q ? wdata_q[HALF_W-1:BYTE_W] : '0;
                if (!wr_q) rdata_d[HALF_W-1:BYTE_W] = bus.DataOut;
                state_d = RESP;
            end
            RESP: begin
                bus.RspValid = 1'b1;
                if (!wr_q) begin
                    if (wide_q)     bus.RspRData = rdata_q;
                    else if (sgn_q) bus.RspRData = sext8to16(rdata_q[BYTE_W-1:0]);
                    else            bus.RspRData = {{BYTE_W{1'b0}}, rdata_q[BYTE_W-1:0]};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
